// File: rtl/display_pkg.sv
// Shared types and constants for the scanned hex display controller.
//   seg_t      : 7-bit active-low segment vector, bit order gfedcba
//   SEG_BLANK  : all segments off
//   HEX_SEG    : hex digit 0-F to segment pattern table
//   CTRL_*     : bit positions inside the 3-bit control register
package display_pkg;
  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'h7F;

  localparam seg_t HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  localparam int CTRL_EN    = 0;
  localparam int CTRL_LZS   = 1;
  localparam int CTRL_BLINK = 2;
endpackage

// File: rtl/scanned_display_controller_if.sv
// CPU-side register bus of the display controller.
//   wr_en_i/wr_data_i : value write strobe and data (nibble k -> digit k)
//   ctrl_wr_i/ctrl_i  : control write strobe and data {blink, lzs, en}
//   bright_i          : anode duty (used only when DISPLAY_PWM_EN is defined)
//   pending_o         : shadow holds a value not yet shown
// master = CPU / bench side, slave = controller.
interface scanned_display_controller_if #(
  parameter int NUM_DIGITS = 6
);
  logic                    wr_en_i;
  logic [4*NUM_DIGITS-1:0] wr_data_i;
  logic                    ctrl_wr_i;
  logic [2:0]              ctrl_i;
  logic [3:0]              bright_i;
  logic                    pending_o;

  modport master (output wr_en_i, wr_data_i, ctrl_wr_i, ctrl_i, bright_i,
                  input  pending_o);
  modport slave  (input  wr_en_i, wr_data_i, ctrl_wr_i, ctrl_i, bright_i,
                  output pending_o);
endinterface

// File: rtl/hex_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder with blanking.
//   nib_i   : hex digit
//   blank_i : force all segments off
//   seg_o   : segment pattern, gfedcba, active-low
module hex_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  input  logic       blank_i,
  output seg_t       seg_o
);
  assign seg_o = blank_i ? SEG_BLANK : HEX_SEG[nib_i];
endmodule

// File: rtl/scanned_display_controller.sv
// Time-multiplexed hex display driver with a double-buffered value register.
// CPU writes land in a shadow register that is copied to the displayed
// (active) register only at the end of a full scan frame, so a digit never
// shows a half-updated value.
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : CPU register bus (slave modport)
//   seg_o       : shared segment bus, active-low gfedcba
//   an_o        : digit enables, active-low, one digit at a time
//   hex_flat_o  : static per-digit segments, digit k at [7k+6:7k]
// Optional: define DISPLAY_PWM_EN to dim the anodes by bright_i.
module scanned_display_controller
  import display_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int CLK_HZ     = 50000000,
  parameter int SCAN_HZ    = 1000,
  parameter int BLINK_HZ   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  scanned_display_controller_if.slave bus,
  output seg_t                    seg_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [7*NUM_DIGITS-1:0] hex_flat_o
);
  localparam int TPD        = CLK_HZ / SCAN_HZ;
  localparam int BLINK_HALF = CLK_HZ / (2 * BLINK_HZ);
  localparam int PW         = $clog2(TPD);
  localparam int BW         = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam int DW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
    $error("NUM_DIGITS must be 1..8");
  end
  if ((CLK_HZ % SCAN_HZ) != 0 || TPD < 16) begin : g_bad_scan
    $error("CLK_HZ/SCAN_HZ must divide exactly and be >= 16");
  end
  if ((CLK_HZ % (2 * BLINK_HZ)) != 0) begin : g_bad_blink
    $error("CLK_HZ/(2*BLINK_HZ) must divide exactly");
  end

  logic [PW-1:0]                 presc_q, presc_d;
  logic [DW-1:0]                 dig_q, dig_d;
  logic [NUM_DIGITS-1:0][3:0]    shadow_q, shadow_d, active_q, active_d;
  logic                          pending_q, pending_d;
  logic [2:0]                    ctrl_q, ctrl_d;
  logic [BW-1:0]                 blink_cnt_q, blink_cnt_d;
  logic                          blink_on_q, blink_on_d;
  seg_t                          seg_q, seg_d;
  logic [NUM_DIGITS-1:0]         an_q, an_d;
  logic [NUM_DIGITS-1:0][6:0]    hex_q, hex_d;

  logic                          presc_tc, frame_end, blink_tc, lz_run, anode_on;
  logic [NUM_DIGITS-1:0]         blank_vec;
  seg_t                          scan_seg;
  logic [NUM_DIGITS-1:0][6:0]    flat_seg;

`ifdef DISPLAY_PWM_EN
  // Anode stays on for the first (bright+1)/16 of each digit slot.
  assign anode_on = int'(presc_q) < ((int'(bus.bright_i) + 1) * TPD) / 16;
`else
  logic unused_bright;
  assign unused_bright = ^bus.bright_i;
  assign anode_on      = 1'b1;
`endif

  // Decoders: one for the scanned bus, one per digit for the static outputs.
  hex_to_7seg u_scan (
    .nib_i   (active_q[dig_q]),
    .blank_i (blank_vec[dig_q]),
    .seg_o   (scan_seg)
  );

  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_flat
    hex_to_7seg u_dec (
      .nib_i   (active_q[k]),
      .blank_i (blank_vec[k]),
      .seg_o   (flat_seg[k])
    );
  end

  always_comb begin
    presc_tc  = (presc_q == PW'(TPD - 1));
    frame_end = presc_tc && (dig_q == DW'(NUM_DIGITS - 1));
    presc_d   = presc_tc ? '0 : presc_q + 1'b1;
    dig_d     = dig_q;
    if (presc_tc) dig_d = frame_end ? '0 : dig_q + 1'b1;

    // Copy before the write so a coincident write stays pending for the next frame.
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frame_end && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (bus.wr_en_i) begin
      shadow_d  = bus.wr_data_i;
      pending_d = 1'b1;
    end

    ctrl_d = bus.ctrl_wr_i ? bus.ctrl_i : ctrl_q;

    blink_tc    = (blink_cnt_q == BW'(BLINK_HALF - 1));
    blink_cnt_d = blink_tc ? '0 : blink_cnt_q + 1'b1;
    blink_on_d  = blink_on_q ^ blink_tc;

    // Leading-zero run from the MSB down; digit 0 always shown.
    blank_vec = '0;
    lz_run    = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run       = lz_run & (active_q[k] == 4'h0);
      blank_vec[k] = ctrl_q[CTRL_LZS] & lz_run;
    end
    if (ctrl_q[CTRL_BLINK] && !blink_on_q) blank_vec = '1;

    seg_d = ctrl_q[CTRL_EN] ? scan_seg : SEG_BLANK;
    an_d  = '1;
    if (ctrl_q[CTRL_EN] && anode_on) an_d[dig_q] = 1'b0;
    hex_d = ctrl_q[CTRL_EN] ? flat_seg : '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      dig_q       <= '0;
      shadow_q    <= '0;
      active_q    <= '0;
      pending_q   <= 1'b0;
      ctrl_q      <= '0;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
      hex_q       <= '1;
    end else begin
      presc_q     <= presc_d;
      dig_q       <= dig_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      ctrl_q      <= ctrl_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
      hex_q       <= hex_d;
    end
  end

  assign seg_o         = seg_q;
  assign an_o          = an_q;
  assign hex_flat_o    = hex_q;
  assign bus.pending_o = pending_q;
endmodule

// File: tb/tb_scanned_display_controller.sv
// Self-checking bench for scanned_display_controller (6 digits, 16 cycles per
// digit slot, 32-cycle blink half period). A cycle-count based reference model
// predicts every output each cycle; scenario tasks also check fixed values.
module tb_scanned_display_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_o;
  logic [5:0]  an_o;
  logic [41:0] hex_flat_o;

  int vecs = 0;
  int errs = 0;

  scanned_display_controller_if #(.NUM_DIGITS(6)) bus ();

  scanned_display_controller #(
    .NUM_DIGITS(6), .CLK_HZ(1600), .SCAN_HZ(100), .BLINK_HZ(25)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .seg_o(seg_o), .an_o(an_o), .hex_flat_o(hex_flat_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int unsigned m_n;      // clock edges since reset release
  logic [23:0] m_sh, m_act;
  logic        m_pend;
  logic [2:0]  m_ctrl;
  logic [6:0]  exp_seg;
  logic [5:0]  exp_an;
  logic [41:0] exp_hex;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
      4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
      4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
      4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Segment pattern digit k shows, given value, ctrl and the edge count.
  function automatic logic [6:0] f_digit(input logic [23:0] act, input logic [2:0] c,
                                         input int unsigned n, input int k);
    logic blink_off;
    blink_off = c[2] && ((n / 32) % 2 == 1);
    if (!c[0] || blink_off) return 7'h7F;
    if (c[1] && k > 0 && (act >> (4 * k)) == 24'h0) return 7'h7F;
    return seg_of(act[4*k +: 4]);
  endfunction

  function automatic logic [41:0] f_hex(input logic [23:0] act, input logic [2:0] c,
                                        input int unsigned n);
    logic [41:0] r;
    for (int k = 0; k < 6; k++) r[7*k +: 7] = f_digit(act, c, n, k);
    return r;
  endfunction

  function automatic logic [5:0] f_an(input logic [2:0] c, input int unsigned n,
                                      input logic [3:0] br);
    logic [5:0] one;
    logic       on;
    one = 6'b000001;
    on  = 1'b1;
`ifdef DISPLAY_PWM_EN
    on = (n % 16) < ((int'(br) + 1) * 16) / 16;
`else
    if (br == 4'hF) on = 1'b1;
`endif
    if (!c[0] || !on) return 6'h3F;
    return ~(one << ((n / 16) % 6));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n <= 0; m_sh <= '0; m_act <= '0; m_pend <= 1'b0; m_ctrl <= '0;
      exp_seg <= 7'h7F; exp_an <= 6'h3F; exp_hex <= '1;
    end else begin
      exp_seg <= f_digit(m_act, m_ctrl, m_n, int'((m_n / 16) % 6));
      exp_an  <= f_an(m_ctrl, m_n, bus.bright_i);
      exp_hex <= f_hex(m_act, m_ctrl, m_n);
      if ((m_n % 96) == 95 && m_pend) begin
        m_act  <= m_sh;
        m_pend <= 1'b0;
      end
      if (bus.wr_en_i) begin
        m_sh   <= bus.wr_data_i;
        m_pend <= 1'b1;
      end
      if (bus.ctrl_wr_i) m_ctrl <= bus.ctrl_i;
      m_n <= m_n + 1;
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_en_i = 0; bus.wr_data_i = '0; bus.ctrl_wr_i = 0; bus.ctrl_i = '0; bus.bright_i = 4'hF;
    repeat (3) @(negedge clk);
    vecs++;
    if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {7'h7F, 6'h3F, {42{1'b1}}, 1'b0}) begin
      errs++;
      $display("FAIL reset seg=%h an=%b hex=%h pend=%b (want 7f 111111 all-ones 0)",
               seg_o, an_o, hex_flat_o, bus.pending_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b001; bus.wr_en_i = 1; bus.wr_data_i = 24'h123456;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); bus.ctrl_wr_i = 0; bus.wr_en_i = 0;
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL basic n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    vecs++;
    if (hex_flat_o[6:0] !== 7'h02 || hex_flat_o[41:35] !== 7'h79 || bus.pending_o !== 1'b0) begin
      errs++;
      $display("FAIL basic_fixed d0=%h want 02 d5=%h want 79 pend=%b want 0",
               hex_flat_o[6:0], hex_flat_o[41:35], bus.pending_o);
    end
  endtask

  task automatic test_lzs();
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b011; bus.wr_en_i = 1; bus.wr_data_i = 24'h00A0F0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); bus.ctrl_wr_i = 0; bus.wr_en_i = 0;
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL lzs n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    vecs++;
    if (hex_flat_o[41:14] !== {7'h7F, 7'h7F, 7'h08, 7'h40}) begin
      errs++;
      $display("FAIL lzs_fixed digits5..2=%h want %h", hex_flat_o[41:14], {7'h7F, 7'h7F, 7'h08, 7'h40});
    end
    bus.wr_en_i = 1; bus.wr_data_i = 24'h000000;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); bus.wr_en_i = 0;
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL lzs_zero n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    vecs++;
    if (hex_flat_o !== {{5{7'h7F}}, 7'h40}) begin
      errs++;
      $display("FAIL lzs_zero_fixed hex=%h want %h", hex_flat_o, {{5{7'h7F}}, 7'h40});
    end
  endtask

  task automatic test_frame_end_write();
    int guard;
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b001;
    guard = 0;
    do begin
      @(negedge clk); bus.ctrl_wr_i = 0; guard++;
    end while ((m_n % 96) != 40 && guard < 300);
    bus.wr_en_i = 1; bus.wr_data_i = 24'h111111;
    do begin
      @(negedge clk); bus.wr_en_i = 0;
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL fe_wait n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end while ((m_n % 96) != 95);
    bus.wr_en_i = 1; bus.wr_data_i = 24'h222222;   // lands on the frame-end edge
    @(negedge clk); bus.wr_en_i = 0;
    vecs++;
    if (bus.pending_o !== 1'b1) begin
      errs++;
      $display("FAIL fe_pending pend=%b want 1", bus.pending_o);
    end
    @(negedge clk);
    vecs++;
    if (hex_flat_o !== {6{7'h79}}) begin
      errs++;
      $display("FAIL fe_old_shadow hex=%h want %h", hex_flat_o, {6{7'h79}});
    end
    for (int i = 0; i < 96; i++) begin
      @(negedge clk);
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL fe_next n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    vecs++;
    if (hex_flat_o !== {6{7'h24}} || bus.pending_o !== 1'b0) begin
      errs++;
      $display("FAIL fe_new hex=%h want %h pend=%b want 0", hex_flat_o, {6{7'h24}}, bus.pending_o);
    end
  endtask

  task automatic test_blink();
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b101; bus.wr_en_i = 1; bus.wr_data_i = 24'($urandom);
    for (int i = 0; i < 260; i++) begin
      @(negedge clk); bus.ctrl_wr_i = 0; bus.wr_en_i = 0;
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL blink n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      bus.wr_en_i   = ($urandom_range(0, 19) == 0);
      bus.wr_data_i = ($urandom_range(0, 2) == 0) ? 24'($urandom_range(0, 255)) : 24'($urandom);
      bus.ctrl_wr_i = ($urandom_range(0, 79) == 0);
      bus.ctrl_i    = 3'($urandom_range(0, 7)) | 3'b001;
      if ($urandom_range(0, 4) == 0) bus.ctrl_i[0] = 1'b0;
      bus.bright_i  = 4'($urandom);
      @(negedge clk);
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL random n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    bus.wr_en_i = 0; bus.ctrl_wr_i = 0; bus.bright_i = 4'hF;
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b001;
    do begin
      @(negedge clk); bus.ctrl_wr_i = 0; guard++;
    end while ((m_n % 96) != 20 && guard < 300);
    bus.wr_en_i = 1; bus.wr_data_i = 24'h89ABCD;
    repeat (5) @(negedge clk);
    bus.wr_en_i = 0;
    #2 rst_n = 1'b0;
    #1;
    vecs++;
    if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {7'h7F, 6'h3F, {42{1'b1}}, 1'b0}) begin
      errs++;
      $display("FAIL reset_mid seg=%h an=%b hex=%h pend=%b (want 7f 111111 all-ones 0)",
               seg_o, an_o, hex_flat_o, bus.pending_o);
    end
    @(negedge clk); rst_n = 1'b1; bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b001;
    @(negedge clk); bus.ctrl_wr_i = 0;
    @(negedge clk);
    vecs++;
    if (an_o !== 6'b111110) begin
      errs++;
      $display("FAIL restart_digit0 an=%b want 111110", an_o);
    end
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      vecs++;
      if ({seg_o, an_o, hex_flat_o, bus.pending_o} !== {exp_seg, exp_an, exp_hex, m_pend}) begin
        errs++;
        $display("FAIL after_reset n=%0d seg=%h/%h an=%b/%b hex=%h/%h pend=%b/%b", m_n, seg_o, exp_seg,
                 an_o, exp_an, hex_flat_o, exp_hex, bus.pending_o, m_pend);
      end
    end
    vecs++;
    if (hex_flat_o !== {6{7'h40}}) begin
      errs++;
      $display("FAIL lost_write hex=%h want %h", hex_flat_o, {6{7'h40}});
    end
  endtask

  task automatic test_pwm();
    int lows;
    bus.ctrl_wr_i = 1; bus.ctrl_i = 3'b001;
    for (int b = 0; b < 2; b++) begin
      bus.bright_i = (b == 0) ? 4'd3 : 4'd15;
      repeat (4) @(negedge clk);
      bus.ctrl_wr_i = 0;
      lows = 0;
      for (int i = 0; i < 96; i++) begin
        @(negedge clk);
        if (an_o !== 6'h3F) lows++;
        vecs++;
        if (an_o !== exp_an) begin
          errs++;
          $display("FAIL pwm n=%0d an=%b want %b", m_n, an_o, exp_an);
        end
      end
`ifdef DISPLAY_PWM_EN
      vecs++;
      if (lows != ((b == 0) ? 24 : 96)) begin
        errs++;
        $display("FAIL pwm_duty bright=%0d low cycles=%0d want %0d", bus.bright_i, lows, (b == 0) ? 24 : 96);
      end
`else
      vecs++;
      if (lows != 96) begin
        errs++;
        $display("FAIL full_duty bright=%0d low cycles=%0d want 96", bus.bright_i, lows);
      end
`endif
    end
    bus.bright_i = 4'hF;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_lzs();
    test_frame_end_write();
    test_blink();
    test_pwm();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
